// File: rtl/mcpu_pkg.sv
// rtl/mcpu_pkg.sv - state, opcode/funct, ALU and select encodings for the multi-cycle MIPS controller
package mcpu_pkg;

   typedef enum logic [4:0] {
      S_IF   = 5'd0,
      S_ID   = 5'd1,
      S_MA   = 5'd2,
      S_MRD  = 5'd3,
      S_MWB  = 5'd4,
      S_MWR  = 5'd5,
      S_RX   = 5'd6,
      S_RWB  = 5'd7,
      S_IX   = 5'd8,
      S_IWB  = 5'd9,
      S_BEQ  = 5'd10,
      S_BNE  = 5'd11,
      S_J    = 5'd12,
      S_JAL  = 5'd13,
      S_JR   = 5'd14,
      S_INT  = 5'd15,
      S_ERET = 5'd16
   } state_t;

   typedef enum logic [2:0] {
      AC_NONE, AC_ADD, AC_SUB, AC_OR, AC_FUNCT, AC_IMM
   } alu_cls_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LUI   = 6'b001111;
`ifdef MCPU_INT_EN
   localparam logic [5:0] OP_COP0  = 6'b010000;
   localparam logic [5:0] FN_ERET  = 6'b011000;
`endif

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_XOR   = 6'b100110;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b011;
   localparam logic [2:0] ALU_NOR = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] M2R_ALU = 2'b00;
   localparam logic [1:0] M2R_MDR = 2'b01;
   localparam logic [1:0] M2R_PC  = 2'b10;
   localparam logic [1:0] M2R_LUI = 2'b11;

   localparam logic [1:0] RD_RT = 2'b00;
   localparam logic [1:0] RD_RD = 2'b01;
   localparam logic [1:0] RD_RA = 2'b10;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;
   localparam logic [1:0] PCS_EPC    = 2'b11;

   localparam logic [1:0] SRCB_RT   = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BR   = 2'b11;

   // Execute state chosen after decode; S_IF means the opcode runs as a NOP.
   function automatic state_t decode_op(input logic [5:0] op, input logic [5:0] fn);
      state_t s;
      case (op)
         OP_RTYPE:                                 s = (fn == FN_JR) ? S_JR : S_RX;
         OP_LW, OP_SW:                             s = S_MA;
         OP_BEQ:                                   s = S_BEQ;
         OP_BNE:                                   s = S_BNE;
         OP_J:                                     s = S_J;
         OP_JAL:                                   s = S_JAL;
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: s = S_IX;
         default:                                  s = S_IF;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/mcpu_alu_dec.sv
// rtl/mcpu_alu_dec.sv - maps the current state class plus opcode/funct to a 3-bit ALU operation
module mcpu_alu_dec
   import mcpu_pkg::*;
(
   input  alu_cls_t   cls,
   input  logic [5:0] op,
   input  logic [5:0] fn,
   output logic [2:0] code
);

   always_comb begin
      code = ALU_AND;
      case (cls)
         AC_ADD: code = ALU_ADD;
         AC_SUB: code = ALU_SUB;
         AC_OR:  code = ALU_OR;
         AC_FUNCT: begin
            case (fn)
               FN_ADD, FN_ADDU: code = ALU_ADD;
               FN_SUB, FN_SUBU: code = ALU_SUB;
               FN_AND:          code = ALU_AND;
               FN_OR:           code = ALU_OR;
               FN_XOR:          code = ALU_XOR;
               FN_NOR:          code = ALU_NOR;
               FN_SLT:          code = ALU_SLT;
               FN_SRL:          code = ALU_SRL;
               default:         code = ALU_ADD;
            endcase
         end
         AC_IMM: begin
            case (op)
               OP_ANDI: code = ALU_AND;
               OP_ORI:  code = ALU_OR;
               OP_SLTI: code = ALU_SLT;
               default: code = ALU_ADD;
            endcase
         end
         default: code = ALU_AND;
      endcase
   end

endmodule

// File: rtl/mcpu_ctrl.sv
// rtl/mcpu_ctrl.sv - multi-cycle MIPS control FSM with MIO_ready wait timer
// Optional interrupt/eret support is built when MCPU_INT_EN is defined.
module mcpu_ctrl
   import mcpu_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15,
   parameter int ALU_CTRL_W   = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [5:0]            OPcode,
   input  logic [5:0]            Fun,
   input  logic                  zero,
   input  logic                  MIO_ready,
   input  logic                  INT,
   output logic                  PCWrite,
   output logic                  PCWriteCond,
   output logic                  PCWriteCondN,
   output logic                  IorD,
   output logic                  IRWrite,
   output logic                  MemRead,
   output logic                  mem_w,
   output logic                  CPU_MIO,
   output logic [1:0]            MemtoReg,
   output logic [1:0]            RegDst,
   output logic                  RegWrite,
   output logic                  ALUSrc_A,
   output logic [1:0]            ALUSrc_B,
   output logic [ALU_CTRL_W-1:0] ALU_Control,
   output logic [1:0]            PCSource,
   output logic                  EPCWrite,
   output logic                  bus_err,
   output logic [4:0]            state_out
);

   state_t     state;
   state_t     id_dest;
   state_t     ret_state;
   alu_cls_t   alu_cls;
   logic [2:0] alu_code;
   logic [7:0] timer;
   logic       wait_st;
   logic       timeout;
   logic       unused_in;

`ifdef MCPU_INT_EN
   logic in_isr;
   // Every return to fetch is diverted to the interrupt state when one is pending.
   assign ret_state = (INT && !in_isr) ? S_INT : S_IF;
   assign unused_in = zero;
`else
   assign ret_state = S_IF;
   assign unused_in = zero ^ INT;
`endif

   assign wait_st   = (state == S_IF) || (state == S_MRD) || (state == S_MWR);
   assign timeout   = wait_st && !MIO_ready && (timer == 8'(MEM_WAIT_MAX));
   assign bus_err   = timeout;
   assign state_out = state;

   always_comb begin
      id_dest = decode_op(OPcode, Fun);
`ifdef MCPU_INT_EN
      if (OPcode == OP_COP0 && Fun == FN_ERET) id_dest = S_ERET;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IF;
         timer <= 8'd0;
`ifdef MCPU_INT_EN
         in_isr <= 1'b0;
`endif
      end else begin
         timer <= (wait_st && !MIO_ready && !timeout) ? timer + 8'd1 : 8'd0;
         case (state)
            S_IF:  if (MIO_ready) state <= S_ID; else if (timeout) state <= ret_state;
            S_ID:  state <= (id_dest == S_IF) ? ret_state : id_dest;
            S_MA:  state <= (OPcode == OP_LW) ? S_MRD : S_MWR;
            S_MRD: if (MIO_ready) state <= S_MWB; else if (timeout) state <= ret_state;
            S_MWR: if (MIO_ready || timeout) state <= ret_state;
            S_RX:  state <= S_RWB;
            S_IX:  state <= S_IWB;
`ifdef MCPU_INT_EN
            S_INT: begin
               in_isr <= 1'b1;
               state  <= S_IF;
            end
            S_ERET: begin
               in_isr <= 1'b0;
               state  <= ret_state;
            end
`endif
            default: state <= ret_state;
         endcase
      end
   end

   always_comb begin
      PCWrite      = 1'b0;
      PCWriteCond  = 1'b0;
      PCWriteCondN = 1'b0;
      IorD         = 1'b0;
      IRWrite      = 1'b0;
      MemRead      = 1'b0;
      mem_w        = 1'b0;
      CPU_MIO      = 1'b0;
      MemtoReg     = M2R_ALU;
      RegDst       = RD_RT;
      RegWrite     = 1'b0;
      ALUSrc_A     = 1'b0;
      ALUSrc_B     = SRCB_RT;
      PCSource     = PCS_ALU;
      EPCWrite     = 1'b0;
      alu_cls      = AC_NONE;
      case (state)
         S_IF: begin
            MemRead  = 1'b1;
            CPU_MIO  = 1'b1;
            ALUSrc_B = SRCB_FOUR;
            alu_cls  = AC_ADD;
            // Writes are held off while reset is low even though the state already reads IF.
            IRWrite  = MIO_ready && reset;
            PCWrite  = MIO_ready && reset;
         end
         S_ID: begin
            ALUSrc_B = SRCB_BR;
            alu_cls  = AC_ADD;
         end
         S_MA: begin
            ALUSrc_A = 1'b1;
            ALUSrc_B = SRCB_IMM;
            alu_cls  = AC_ADD;
         end
         S_MRD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
            CPU_MIO = 1'b1;
         end
         S_MWB: begin
            MemtoReg = M2R_MDR;
            RegWrite = 1'b1;
         end
         S_MWR: begin
            IorD    = 1'b1;
            mem_w   = 1'b1;
            CPU_MIO = 1'b1;
         end
         S_RX: begin
            ALUSrc_A = 1'b1;
            alu_cls  = AC_FUNCT;
         end
         S_RWB: begin
            RegDst   = RD_RD;
            RegWrite = 1'b1;
         end
         S_IX: begin
            // Immediate ops still need rs on the A side.
            ALUSrc_A = 1'b1;
            ALUSrc_B = SRCB_IMM;
            alu_cls  = AC_IMM;
         end
         S_IWB: begin
            MemtoReg = (OPcode == OP_LUI) ? M2R_LUI : M2R_ALU;
            RegWrite = 1'b1;
         end
         S_BEQ, S_BNE: begin
            ALUSrc_A     = 1'b1;
            alu_cls      = AC_SUB;
            PCSource     = PCS_ALUOUT;
            PCWriteCond  = (state == S_BEQ);
            PCWriteCondN = (state == S_BNE);
         end
         S_J: begin
            PCSource = PCS_JUMP;
            PCWrite  = 1'b1;
         end
         S_JAL: begin
            PCSource = PCS_JUMP;
            PCWrite  = 1'b1;
            RegDst   = RD_RA;
            MemtoReg = M2R_PC;
            RegWrite = 1'b1;
         end
         S_JR: begin
            ALUSrc_A = 1'b1;
            alu_cls  = AC_OR;
            PCWrite  = 1'b1;
         end
`ifdef MCPU_INT_EN
         S_INT: begin
            EPCWrite = 1'b1;
            PCSource = PCS_EPC;
            PCWrite  = 1'b1;
         end
         S_ERET: begin
            PCSource = PCS_EPC;
            PCWrite  = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   mcpu_alu_dec u_alu_dec (
      .cls  (alu_cls),
      .op   (OPcode),
      .fn   (Fun),
      .code (alu_code)
   );

   assign ALU_Control = ALU_CTRL_W'(alu_code);

endmodule

// File: tb/tb_mcpu_ctrl.sv
// tb/tb_mcpu_ctrl.sv - directed plus randomized instruction sequences against a per-instruction control model
module tb_mcpu_ctrl;
   import mcpu_pkg::*;

   typedef struct packed {
      logic       pc_w, pc_wc, pc_wcn, iord, ir_w, mem_rd, mem_wr, mio;
      logic [1:0] m2r, rdst;
      logic       reg_w, src_a;
      logic [1:0] src_b;
      logic [2:0] alu;
      logic [1:0] pc_src;
      logic       epc_w, berr;
   } ctl_t;

   typedef struct {
      logic  mio;
      ctl_t  exp;
      string tag;
   } step_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] OPcode = 6'd0, Fun = 6'd0;
   logic       zero = 1'b0, MIO_ready = 1'b0, INT = 1'b0;
   logic       PCWrite, PCWriteCond, PCWriteCondN, IorD, IRWrite, MemRead, mem_w, CPU_MIO;
   logic [1:0] MemtoReg, RegDst, ALUSrc_B, PCSource;
   logic       RegWrite, ALUSrc_A, EPCWrite, bus_err;
   logic [2:0] ALU_Control;
   logic [4:0] state_out;

   ctl_t  obs, mwr_vec;
   step_t q[$];
   int    vectors = 0;
   int    miscompares = 0;
   logic [5:0] op, fn;

   logic [5:0] ops [16] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02,
                            6'h03, 6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h0f, 6'h10, 6'h3f};
   logic [5:0] fns [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                            6'h26, 6'h27, 6'h2a, 6'h02, 6'h08, 6'h38};

   always #5 clk = ~clk;

   mcpu_ctrl #(.MEM_WAIT_MAX(15), .ALU_CTRL_W(3)) dut (
      .clk(clk), .reset(reset), .OPcode(OPcode), .Fun(Fun), .zero(zero),
      .MIO_ready(MIO_ready), .INT(INT), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .PCWriteCondN(PCWriteCondN), .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead),
      .mem_w(mem_w), .CPU_MIO(CPU_MIO), .MemtoReg(MemtoReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrc_A(ALUSrc_A), .ALUSrc_B(ALUSrc_B),
      .ALU_Control(ALU_Control), .PCSource(PCSource), .EPCWrite(EPCWrite),
      .bus_err(bus_err), .state_out(state_out)
   );

   assign obs = {PCWrite, PCWriteCond, PCWriteCondN, IorD, IRWrite, MemRead, mem_w, CPU_MIO,
                 MemtoReg, RegDst, RegWrite, ALUSrc_A, ALUSrc_B, ALU_Control, PCSource,
                 EPCWrite, bus_err};

   function automatic logic [2:0] r_code(input logic [5:0] f);
      case (f)
         6'h20, 6'h21: return 3'b010;
         6'h22, 6'h23: return 3'b110;
         6'h24: return 3'b000;
         6'h25: return 3'b001;
         6'h26: return 3'b011;
         6'h27: return 3'b100;
         6'h2a: return 3'b111;
         6'h02: return 3'b101;
         default: return 3'b010;
      endcase
   endfunction

   function automatic logic [2:0] i_code(input logic [5:0] o);
      case (o)
         6'h0c: return 3'b000;
         6'h0d: return 3'b001;
         6'h0a: return 3'b111;
         default: return 3'b010;
      endcase
   endfunction

   function automatic ctl_t fetch_vec(input logic done);
      ctl_t c = '0;
      c.mem_rd = 1'b1; c.mio = 1'b1; c.src_b = 2'b01; c.alu = 3'b010;
      c.pc_w = done; c.ir_w = done;
      return c;
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic m, input ctl_t c, input string t);
      step_t s;
      s.mio = m; s.exp = c; s.tag = t;
      q.push_back(s);
   endtask

   task automatic check(input ctl_t exp, input string tag);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_if(input string tag);
      vectors++;
      assert (state_out === S_IF)
      else begin
         miscompares++;
         $error("FAIL %s observed_state=%0d expected_state=%0d", tag, state_out, S_IF);
      end
   endtask

   // Expected per-cycle control words for one instruction with the given bus waits.
   task automatic build(input logic [5:0] o, input logic [5:0] f, input int wif, input int wmem,
                        input bit mem_to);
      ctl_t c;
      q.delete();
      for (int i = 0; i < wif; i++) push(1'b0, fetch_vec(1'b0), "if_wait");
      push(1'b1, fetch_vec(1'b1), "if_done");
      c = '0; c.src_b = 2'b11; c.alu = 3'b010;
      push(rnd_bit(), c, "id");
      if (o == 6'h00 && f == 6'h08) begin
         c = '0; c.src_a = 1'b1; c.alu = 3'b001; c.pc_w = 1'b1;
         push(rnd_bit(), c, "jr");
      end else if (o == 6'h00) begin
         c = '0; c.src_a = 1'b1; c.alu = r_code(f);
         push(rnd_bit(), c, "rx");
         c = '0; c.rdst = 2'b01; c.reg_w = 1'b1;
         push(rnd_bit(), c, "rwb");
      end else if (o == 6'h23 || o == 6'h2b) begin
         c = '0; c.src_a = 1'b1; c.src_b = 2'b10; c.alu = 3'b010;
         push(rnd_bit(), c, "ma");
         c = '0; c.iord = 1'b1; c.mio = 1'b1;
         if (o == 6'h23) c.mem_rd = 1'b1; else c.mem_wr = 1'b1;
         for (int i = 0; i < wmem; i++) push(1'b0, c, "mem_wait");
         if (mem_to) begin
            c.berr = 1'b1;
            push(1'b0, c, "mem_timeout");
         end else begin
            push(1'b1, c, "mem_done");
            if (o == 6'h23) begin
               c = '0; c.m2r = 2'b01; c.reg_w = 1'b1;
               push(rnd_bit(), c, "mwb");
            end
         end
      end else if (o == 6'h04 || o == 6'h05) begin
         c = '0; c.src_a = 1'b1; c.alu = 3'b110; c.pc_src = 2'b01;
         if (o == 6'h04) c.pc_wc = 1'b1; else c.pc_wcn = 1'b1;
         push(rnd_bit(), c, (o == 6'h04) ? "beq" : "bne");
      end else if (o == 6'h02 || o == 6'h03) begin
         c = '0; c.pc_src = 2'b10; c.pc_w = 1'b1;
         if (o == 6'h03) begin
            c.rdst = 2'b10; c.m2r = 2'b10; c.reg_w = 1'b1;
         end
         push(rnd_bit(), c, (o == 6'h03) ? "jal" : "j");
      end else if (o inside {6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h0f}) begin
         c = '0; c.src_a = 1'b1; c.src_b = 2'b10; c.alu = i_code(o);
         push(rnd_bit(), c, "ix");
         c = '0; c.m2r = (o == 6'h0f) ? 2'b11 : 2'b00; c.reg_w = 1'b1;
         push(rnd_bit(), c, "iwb");
      end
   endtask

   task automatic build_if_timeout();
      ctl_t c;
      q.delete();
      for (int i = 0; i < 15; i++) push(1'b0, fetch_vec(1'b0), "if_wait_to");
      c = fetch_vec(1'b0); c.berr = 1'b1;
      push(1'b0, c, "if_timeout");
   endtask

   // Entered on a falling edge; each step drives, checks 1 ns later, then waits a full cycle.
   task automatic play();
      foreach (q[i]) begin
         MIO_ready = q[i].mio;
         zero      = rnd_bit();
         INT       = rnd_bit();
         #1;
         if (i == 0) check_if("state_at_fetch");
         check(q[i].exp, q[i].tag);
         @(negedge clk);
      end
   endtask

   task automatic run(input logic [5:0] o, input logic [5:0] f, input int wif, input int wmem,
                      input bit mem_to);
      OPcode = o; Fun = f;
      build(o, f, wif, wmem, mem_to);
      play();
   endtask

   initial begin
      #1 reset = 1'b0;
      #1;
      check(fetch_vec(1'b0), "reset_levels");
      check_if("reset_state");
      @(negedge clk);
      MIO_ready = 1'b1;
      #1;
      check(fetch_vec(1'b0), "reset_ready_gated");
      @(negedge clk);
      reset = 1'b1;

      run(6'h23, 6'h00, 0, 2, 1'b0);
      run(6'h04, 6'h00, 0, 0, 1'b0);
      run(6'h05, 6'h00, 0, 0, 1'b0);
      run(6'h03, 6'h00, 0, 0, 1'b0);
      run(6'h00, 6'h20, 1, 0, 1'b0);

      build_if_timeout();
      play();
      run(6'h00, 6'h20, 15, 0, 1'b0);
      run(6'h23, 6'h00, 0, 15, 1'b1);
      run(6'h2b, 6'h00, 2, 15, 1'b1);
      run(6'h10, 6'h18, 0, 0, 1'b0);

      OPcode = 6'h2b; Fun = 6'h00;
      build(6'h2b, 6'h00, 0, 2, 1'b0);
      void'(q.pop_back());
      play();
      mwr_vec = '0; mwr_vec.iord = 1'b1; mwr_vec.mio = 1'b1; mwr_vec.mem_wr = 1'b1;
      MIO_ready = 1'b0;
      #1;
      check(mwr_vec, "mwr_before_reset");
      #1;
      MIO_ready = 1'b1;
      reset = 1'b0;
      #1;
      check(fetch_vec(1'b0), "async_reset_in_mwr");
      check_if("async_reset_state");
      @(negedge clk);
      reset = 1'b1;
      run(6'h0f, 6'h00, 0, 0, 1'b0);

      for (int n = 0; n < 80; n++) begin
         op = ops[$urandom_range(0, 15)];
         fn = (op == 6'h00) ? fns[$urandom_range(0, 11)] : 6'($urandom);
         run(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mcpu_ctrl.md
# mcpu_ctrl

Multi-cycle MIPS control unit: the successor to the single-cycle controller, driving a shared-memory multi-cycle datapath through a state machine. Each instruction is split into fetch, decode, execute, memory and write-back states. Every memory access is stretched by the `MIO_ready` handshake, with a bounded wait timer. It sits beside the multi-cycle datapath inside the CPU top and talks to the memory/IO bus through `mem_w` and `CPU_MIO`.

## Interface
- `MEM_WAIT_MAX`, default 15: maximum wait cycles for `MIO_ready` before a bus timeout; legal range 1..255.
- `ALU_CTRL_W`, default 3: width of `ALU_Control`.
- `clk` in 1: the single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `OPcode` in 6: IR[31:26].
- `Fun` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `MIO_ready` in 1: the bus completes the current access this cycle.
- `INT` in 1: level interrupt request; used only with `MCPU_INT_EN`.
- `PCWrite`, `PCWriteCond`, `PCWriteCondN` out 1 each: unconditional PC write, and PC write on `zero` / on `!zero`.
- `IorD` out 1: memory address source; 0 = PC, 1 = ALUOut.
- `IRWrite` out 1: instruction register write.
- `MemRead` out 1: memory read request.
- `mem_w` out 1: memory write request.
- `CPU_MIO` out 1: a bus access (read or write) is in progress.
- `MemtoReg` out 2: write-back source; 00 ALUOut, 01 MDR, 10 PC (jal), 11 lui immediate.
- `RegDst` out 2: destination register; 00 rt, 01 rd, 10 $31.
- `RegWrite` out 1: register-file write.
- `ALUSrc_A` out 1: ALU A source; 0 = PC, 1 = rs.
- `ALUSrc_B` out 2: ALU B source; 00 rt, 01 const 4, 10 sign-extended immediate, 11 sign-extended immediate << 2.
- `ALU_Control` out `ALU_CTRL_W`: ALU operation code.
- `PCSource` out 2: 00 ALU result, 01 ALUOut, 10 jump target, 11 EPC/vector.
- `EPCWrite` out 1: EPC write; constant 0 without `MCPU_INT_EN`.
- `bus_err` out 1: one-cycle pulse on a bus wait timeout.
- `state_out` out 5: current state, for debug.

## Operation
- States:
  - IF
  - ID
  - MA (memory address)
  - MRD, MWB
  - MWR
  - RX, RWB
  - IX, IWB
  - BEQ, BNE
  - J, JAL, JR
  - INT (macro only)
  - ERET (macro only)
- IF: `MemRead`=1, `CPU_MIO`=1, `ALUSrc_A`=0, `ALUSrc_B`=01, ALU add, `PCSource`=00.
  - `IRWrite` and `PCWrite` assert only in a cycle with `MIO_ready`=1; that cycle also moves the FSM to ID.
- ID: `ALUSrc_B`=11, ALU add (branch target into ALUOut). Next state by opcode:
  - 000000: funct 001000 → JR, else → RX.
  - 100011 / 101011 → MA.
  - 000100 → BEQ; 000101 → BNE.
  - 000010 → J; 000011 → JAL.
  - 001000 / 001100 / 001101 / 001010 / 001111 → IX.
  - Any other opcode → IF (executed as a NOP, no write).
- MA: `ALUSrc_A`=1, `ALUSrc_B`=10, add. Goes to MRD for lw, MWR for sw.
- MRD: `IorD`=1, `MemRead`=1, `CPU_MIO`=1; holds until `MIO_ready`, then → MWB.
- MWB: `RegDst`=00, `MemtoReg`=01, `RegWrite`=1 → IF.
- MWR: `IorD`=1, `mem_w`=1, `CPU_MIO`=1; holds until `MIO_ready`, then → IF.
- RX: A=rs, B=rt, ALU code from funct. RWB: `RegDst`=01, `MemtoReg`=00, `RegWrite`=1 → IF.
- ALU codes:
  - 000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl, 110 sub, 111 slt.
  - funct map: add/addu → 010, sub/subu → 110, and → 000, or → 001, xor → 011, nor → 100, slt → 111, srl → 101.
  - Unknown funct → 010.
- IX: B=10; addi → add, andi → and, ori → or, slti → slt, lui → add.
- IWB: `RegDst`=00; `MemtoReg`=11 for lui, else 00; `RegWrite`=1.
- BEQ/BNE: A=1, B=00, sub, `PCSource`=01, `PCWriteCond`/`PCWriteCondN`=1 → IF.
- J: `PCSource`=10, `PCWrite`=1. JAL: J plus `RegDst`=10, `MemtoReg`=10, `RegWrite`=1. JR: A=1, ALU pass (or with B=00 rt=$0), `PCSource`=00, `PCWrite`=1.
- Wait timer:
  - Cleared on entry to IF, MRD and MWR; counts each cycle with `MIO_ready`=0.
  - On reaching `MEM_WAIT_MAX`: `bus_err` pulses, no writes occur, FSM → IF (fetch retried).
- Outputs not listed for a state are 0.

## Timing
- `reset` low forces state IF immediately and asynchronously; timer=0, `in_isr`=0.
- While `reset` is low, all outputs are 0 except the IF levels (`MemRead`, `CPU_MIO`, `ALUSrc_B`=01, `ALU_Control`=010); `PCWrite` and `IRWrite` are held 0.
- Zero-wait cycle counts: R/I-type 4, lw 5, sw 4, beq/bne/j/jr/jal 3. Each wait cycle adds one.
- `MIO_ready` is sampled only in IF, MRD and MWR; a stray `MIO_ready` elsewhere is ignored.
- `MIO_ready` in the same cycle as the timeout wins: the access completes and there is no `bus_err`.
- Reset released mid-instruction restarts cleanly at IF.

## Configuration
- `MCPU_INT_EN` defined:
  - `INT` is checked on every transition into IF; if `INT`=1 and `in_isr`=0, go to INT instead.
  - INT state: `EPCWrite`=1, `PCSource`=11, `PCWrite`=1, sets `in_isr`, then → IF.
  - ERET (opcode 010000, funct 011000): `PCSource`=11, `PCWrite`=1, clears `in_isr`, then → IF.
  - The datapath muxes EPC versus the vector 0x00000004 using `in_isr`.
- `MCPU_INT_EN` undefined: INT and ERET states are absent, `INT` is ignored, `EPCWrite`=0, opcode 010000 is a NOP.

## Structure
- `mcpu_pkg` holds state encodings, opcode/funct constants, ALU codes and the `MemtoReg`/`RegDst`/`PCSource` select encodings.
- One combinational sub-module, `mcpu_alu_dec`, maps (state class, opcode, funct) to `ALU_Control`.

## Test plan
- lw with 2 wait cycles (`MIO_ready` low for 2 cycles in MRD) → 7 cycles total, `RegWrite`=1 exactly once in MWB, `MemtoReg`=01.
- beq with `zero`=1, then bne with `zero`=1 → `PCWriteCond`=1 in BEQ, `PCWriteCondN`=1 in BNE, 3 cycles each.
- jal → `RegDst`=10, `MemtoReg`=10, `RegWrite`=1, `PCSource`=10; next `state_out`=IF.
- `MIO_ready` stuck low in IF with `MEM_WAIT_MAX`=15 → single `bus_err` pulse after 15 wait cycles, no `IRWrite`, FSM re-enters IF.
- `reset` asserted in MWR with `mem_w`=1 → `mem_w` drops the same cycle; state=IF with no clock edge needed.
- With `MCPU_INT_EN`: `INT`=1 during an add → add completes, INT state (`EPCWrite`=1), and a second `INT` is blocked until eret.
